// File: rtl/la_rle_expander.sv
// Expands RLE trace packets {rc, la_data} into one sample per cycle on a valid/ready port.
// Optional counters smp_cnt/gap_cnt are built only when LA_EXP_STATS_EN is defined.
module la_rle_expander #(
  parameter int DATA_W = 24,
  parameter int RC_W   = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   flush,
  input  logic [RC_W+DATA_W-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_gap,
  output logic                   o_last,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   err_rc0,
  output logic [31:0]            smp_cnt,
  output logic [15:0]            gap_cnt,
  output logic                   o_dbg_state
);

  // Handshakes: a transfer happens on a port in any cycle where its valid and
  // ready are both 1; a valid sample holds data/gap/last until it is taken.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              r_state, w_state_nx;
  logic [RC_W-1:0]     r_remain, w_remain_nx;
  logic [DATA_W-1:0]   r_data, w_data_nx;
  logic                r_gap, w_gap_nx;
  logic                r_tlast, w_tlast_nx;
  logic                r_err;

  logic [RC_W-1:0]     w_rc;
  logic [DATA_W-1:0]   w_pkt_data;
  logic                w_null, w_rc0, w_accept, w_load, w_hs, w_rem_one;

  assign w_rc       = s_tdata[RC_W+DATA_W-1:DATA_W];
  assign w_pkt_data = s_tdata[DATA_W-1:0];
  assign w_null     = (s_tdata == '0);
  assign w_rc0      = (w_rc == '0) && !w_null;
  assign w_rem_one  = (r_remain == RC_W'(1));

  assign o_valid     = (r_state == RUN);
  assign o_data      = r_data;
  assign o_gap       = r_gap;
  assign o_last      = r_tlast && w_rem_one;
  assign err_rc0     = r_err;
  assign o_dbg_state = r_state;

  assign s_tready = !flush && (!o_valid || (o_ready && w_rem_one));
  assign w_accept = s_tvalid && s_tready;
  assign w_load   = w_accept && !w_rc0;
  assign w_hs     = o_valid && o_ready;

  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    w_data_nx   = r_data;
    w_gap_nx    = r_gap;
    w_tlast_nx  = r_tlast;
    if (flush) begin
      w_state_nx  = IDLE;
      w_remain_nx = '0;
    end else if (w_load) begin
      // A null packet stands for one unknown sample.
      w_state_nx  = RUN;
      w_remain_nx = w_null ? RC_W'(1) : w_rc;
      w_data_nx   = w_null ? '0 : w_pkt_data;
      w_gap_nx    = w_null;
      w_tlast_nx  = s_tlast;
    end else if (w_hs) begin
      if (w_rem_one) begin
        w_state_nx  = IDLE;
        w_remain_nx = '0;
      end else begin
        w_remain_nx = r_remain - RC_W'(1);
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_data   <= '0;
      r_gap    <= 1'b0;
      r_tlast  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_remain <= w_remain_nx;
      r_data   <= w_data_nx;
      r_gap    <= w_gap_nx;
      r_tlast  <= w_tlast_nx;
      if (w_accept && w_rc0) r_err <= 1'b1;
    end
  end

`ifdef LA_EXP_STATS_EN
  logic [31:0] r_smp_cnt;
  logic [15:0] r_gap_cnt;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_smp_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_hs && (r_smp_cnt != 32'hFFFF_FFFF)) r_smp_cnt <= r_smp_cnt + 32'd1;
      if (w_accept && w_null && (r_gap_cnt != 16'hFFFF)) r_gap_cnt <= r_gap_cnt + 16'd1;
    end
  end

  assign smp_cnt = r_smp_cnt;
  assign gap_cnt = r_gap_cnt;
`else
  assign smp_cnt = 32'd0;
  assign gap_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_la_rle_expander.sv
// Directed bench for la_rle_expander: hand-computed expectations per cycle.
module tb_la_rle_expander;

`ifdef LA_EXP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        flush    = 1'b0;
  logic [31:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tready;
  logic [23:0] o_data;
  logic        o_gap, o_last, o_valid;
  logic        o_ready  = 1'b0;
  logic        err_rc0;
  logic [31:0] smp_cnt;
  logic [15:0] gap_cnt;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  la_rle_expander dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .flush       (flush),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .o_data      (o_data),
    .o_gap       (o_gap),
    .o_last      (o_last),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .err_rc0     (err_rc0),
    .smp_cnt     (smp_cnt),
    .gap_cnt     (gap_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; sampling happens 1 unit later
  task automatic tick;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic do_reset;
    axis_rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    flush    = 1'b0;
    o_ready  = 1'b1;
    tick();
    tick();
    axis_rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [31:0] pkt, input logic last);
    s_tdata  = pkt;
    s_tlast  = last;
    s_tvalid = 1'b1;
    #1;
    check("send_tready", 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1;
  endtask

  initial begin
    int hs;
    int bad_d, bad_v, bad_r;

    // reset values
    axis_rst = 1'b1;
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_gap", 32'(o_gap), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_err", 32'(err_rc0), 32'd0);
    check("rst_smp", smp_cnt, 32'd0);
    check("rst_gapcnt", 32'(gap_cnt), 32'd0);
    do_reset();
    check("idle_tready", 32'(s_tready), 32'd1);

    // 1: rc=3 run
    send(32'h0300_ABCD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t1_valid", 32'(o_valid), 32'd1);
      check("t1_data", 32'(o_data), 32'h00AB_CD);
      check("t1_gap", 32'(o_gap), 32'd0);
      tick();
      #1;
    end
    check("t1_idle", 32'(o_valid), 32'd0);

    // 2: back-to-back rc=1 packets, no bubble
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_tdata = {8'h01, 24'(i)};
      #1;
      check("t2_tready", 32'(s_tready), 32'd1);
      if (i > 1) check("t2_data", 32'(o_data), 32'(i - 1));
      tick();
    end
    s_tvalid = 1'b0;
    #1;
    check("t2_valid3", 32'(o_valid), 32'd1);
    check("t2_data3", 32'(o_data), 32'd3);
    tick();
    #1;
    check("t2_idle", 32'(o_valid), 32'd0);

    // 3: null packet -> single gap sample
    send(32'h0000_0000, 1'b0);
    check("t3_valid", 32'(o_valid), 32'd1);
    check("t3_gap", 32'(o_gap), 32'd1);
    check("t3_data", 32'(o_data), 32'd0);
    tick();
    #1;
    check("t3_idle", 32'(o_valid), 32'd0);
    check("t3_gapcnt", 32'(gap_cnt), STATS ? 32'd1 : 32'd0);

    // 4: rc=0 with data -> dropped, sticky error, next packet fine
    send(32'h0000_0055, 1'b0);
    check("t4_novalid", 32'(o_valid), 32'd0);
    check("t4_err", 32'(err_rc0), 32'd1);
    send(32'h0200_0077, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("t4_valid", 32'(o_valid), 32'd1);
      check("t4_data", 32'(o_data), 32'h77);
      check("t4_gap", 32'(o_gap), 32'd0);
      tick();
      #1;
    end
    check("t4_idle", 32'(o_valid), 32'd0);
    check("t4_err_sticky", 32'(err_rc0), 32'd1);
    check("t4_smp", smp_cnt, STATS ? 32'd9 : 32'd0);

    // o_last only on the final sample of a tlast packet
    send(32'h0200_00CC, 1'b1);
    check("last_s1", 32'(o_last), 32'd0);
    tick();
    #1;
    check("last_s2", 32'(o_last), 32'd1);
    check("last_s2_valid", 32'(o_valid), 32'd1);
    tick();
    #1;
    check("last_idle", 32'(o_valid), 32'd0);

    // 5: rc=255 with o_ready toggling
    do_reset();
    send(32'hFF12_3456, 1'b0);
    hs = 0; bad_d = 0; bad_v = 0; bad_r = 0;
    for (int c = 0; c < 1000 && hs < 255; c++) begin
      o_ready = (c % 2) == 0;
      #1;
      if (o_valid !== 1'b1) bad_v++;
      if (o_data !== 24'h12_3456 || o_gap !== 1'b0 || o_last !== 1'b0) bad_d++;
      if (s_tready !== (o_ready && hs == 254)) bad_r++;
      if (o_valid && o_ready) hs++;
      tick();
    end
    o_ready = 1'b1;
    #1;
    check("t5_count", 32'(hs), 32'd255);
    check("t5_valid_held", 32'(bad_v), 32'd0);
    check("t5_data_stable", 32'(bad_d), 32'd0);
    check("t5_tready", 32'(bad_r), 32'd0);
    check("t5_idle", 32'(o_valid), 32'd0);
    check("t5_smp", smp_cnt, STATS ? 32'd255 : 32'd0);

    // 6: flush mid-run, then async reset mid-run
    send(32'h0500_00AA, 1'b1);
    check("t6_s1", 32'(o_valid), 32'd1);
    tick();
    #1;
    check("t6_s2", 32'(o_valid), 32'd1);
    flush    = 1'b1;
    s_tdata  = 32'h0100_0011;
    s_tvalid = 1'b1;
    #1;
    check("t6_flush_tready", 32'(s_tready), 32'd0);
    tick();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    #1;
    check("t6_flush_valid", 32'(o_valid), 32'd0);
    check("t6_flush_last", 32'(o_last), 32'd0);
    check("t6_flush_state", 32'(o_dbg_state), 32'd0);
    tick();
    #1;
    check("t6_flush_stay", 32'(o_valid), 32'd0);

    send(32'h0500_00AA, 1'b1);
    check("t6_run", 32'(o_valid), 32'd1);
    axis_rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_data", 32'(o_data), 32'd0);
    check("t6_rst_last", 32'(o_last), 32'd0);
    check("t6_rst_smp", smp_cnt, 32'd0);
    tick();
    axis_rst = 1'b0;
    tick();
    #1;
    check("t6_post_rst", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
